uart_tx_buf: RTL and testbench

UART_TX_BUF -- requirements
Module: uart_tx_buf

---
 rtl/uart_tx_buf.sv | 214 +++++++++++++++++++++
 tb/tb_uart_tx_buf.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buf.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_buf
// Description : Byte FIFO feeding an 8N1 UART transmitter. Incoming bytes are
//               queued and sent LSB first, with back-to-back frames whenever
//               more data is waiting. Bytes that arrive while the FIFO is full
//               are dropped, and a sticky overflow flag records the drop.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_buf #(
  parameter int CLK_DIV = 104,
  parameter int DEPTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             uart_data,
  input  logic                   uart_valid,
  input  logic                   ovf_clr,
  output logic                   tx,
  output logic                   busy,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] level
);

  localparam int                c_ADDR_W = $clog2(DEPTH);
  localparam int                c_LVL_W  = c_ADDR_W + 1;
  localparam logic [c_LVL_W-1:0] c_FULL  = c_LVL_W'(DEPTH);
  localparam logic [15:0]       c_RELOAD = 16'(CLK_DIV - 1);

  // Reject illegal parameterisations at elaboration time
  generate
    if (CLK_DIV < 2 || CLK_DIV > 65535) begin : g_clk_div_illegal
      $error("uart_tx_buf: CLK_DIV must lie in 2..65535");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_illegal
      $error("uart_tx_buf: DEPTH must be a power of two, at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [7:0]          r_mem [DEPTH];
  logic [c_ADDR_W-1:0] r_wr_ptr;
  logic [c_ADDR_W-1:0] r_rd_ptr;
  logic [c_LVL_W-1:0]  r_level;
  logic [15:0]         r_cnt;
  logic [15:0]         w_cnt_nxt;
  logic [2:0]          r_bit_idx;
  logic [2:0]          w_bit_idx_nxt;
  logic [7:0]          r_shift;
  logic [7:0]          w_shift_nxt;
  logic                r_tx;
  logic                r_active;
  logic                r_ovf;
  logic                w_push;
  logic                w_drop;
  logic                w_pop;
  logic                w_full;
  logic                w_not_empty;
  logic                w_cnt_zero;

  // Fullness is judged on the occupancy before any same-cycle pop, so a pop
  // never makes room for a byte arriving in the same cycle.
  assign w_full      = (r_level == c_FULL);
  assign w_not_empty = (r_level != '0);
  assign w_push      = uart_valid && !w_full;
  assign w_drop      = uart_valid && w_full;
  assign w_cnt_zero  = (r_cnt == 16'd0);

  // Next-state, bit timing and FIFO pop decision for the transmitter
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_pop         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_not_empty) begin
          w_pop         = 1'b1;
          w_shift_nxt   = r_mem[r_rd_ptr];
          w_cnt_nxt     = c_RELOAD;
          w_bit_idx_nxt = 3'd0;
          w_state_nxt   = S_START;
        end
      end
      S_START: begin
        if (w_cnt_zero) begin
          w_cnt_nxt     = c_RELOAD;
          w_bit_idx_nxt = 3'd0;
          w_state_nxt   = S_DATA;
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      S_DATA: begin
        if (w_cnt_zero) begin
          w_cnt_nxt   = c_RELOAD;
          w_shift_nxt = r_shift >> 1;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      S_STOP: begin
        if (w_cnt_zero) begin
          if (w_not_empty) begin
            // Chain straight into the next frame with no idle gap
            w_pop         = 1'b1;
            w_shift_nxt   = r_mem[r_rd_ptr];
            w_cnt_nxt     = c_RELOAD;
            w_bit_idx_nxt = 3'd0;
            w_state_nxt   = S_START;
          end else begin
            w_cnt_nxt   = 16'd0;
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Transmitter state, bit counter and shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 16'd0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  // Line driver: tx and the frame-active flag trail the state by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx     <= 1'b1;
      r_active <= 1'b0;
    end else begin
      case (r_state)
        S_START: r_tx <= 1'b0;
        S_DATA:  r_tx <= r_shift[0];
        default: r_tx <= 1'b1;
      endcase
      r_active <= (r_state != S_IDLE);
    end
  end

  // FIFO pointers (wrap modulo DEPTH) and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + c_LVL_W'(1);
        2'b01:   r_level <= r_level - c_LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // FIFO storage; contents are meaningless while the pointers are reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= uart_data;
    end
  end

  // Sticky overflow flag; a drop wins over a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign tx       = r_tx;
  assign busy     = r_active || w_not_empty;
  assign overflow = r_ovf;
  assign level    = r_level;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_buf
// Description : Self-checking bench for uart_tx_buf. A queue-based reference
//               model predicts tx, busy, overflow and level on every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_buf;

  localparam int CD  = 4;
  localparam int DEP = 16;
  localparam int LW  = $clog2(DEP) + 1;

  logic          clk        = 1'b0;
  logic          rst_n      = 1'b0;
  logic [7:0]    uart_data  = 8'd0;
  logic          uart_valid = 1'b0;
  logic          ovf_clr    = 1'b0;
  logic          tx;
  logic          busy;
  logic          overflow;
  logic [LW-1:0] level;

  uart_tx_buf #(.CLK_DIV(CD), .DEPTH(DEP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .uart_data  (uart_data),
    .uart_valid (uart_valid),
    .ovf_clr    (ovf_clr),
    .tx         (tx),
    .busy       (busy),
    .overflow   (overflow),
    .level      (level)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int peak  = 0;
  int cnt   = 0;

  // Reference model: FIFO as a queue, frame as a cycle position 0..10*CD-1
  logic [7:0] m_q[$];
  bit         m_in_frame;
  int         m_t;
  logic [7:0] m_byte;
  bit         m_ovf;
  logic       m_tx;
  logic       m_active;

  function automatic logic frame_bit(input logic [7:0] b, input int t);
    int p;
    p = t / CD;
    if (p == 0) return 1'b0;
    if (p <= 8) return b[p-1];
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_in_frame = 1'b0;
    m_t        = 0;
    m_byte     = 8'd0;
    m_ovf      = 1'b0;
    m_tx       = 1'b1;
    m_active   = 1'b0;
  endtask

  task automatic model_edge(input logic v, input logic [7:0] d, input logic clr);
    int sz;
    bit pop;
    sz  = m_q.size();
    pop = 1'b0;
    m_tx     = m_in_frame ? frame_bit(m_byte, m_t) : 1'b1;
    m_active = m_in_frame;
    if (!m_in_frame) begin
      pop = (sz > 0);
    end else if (m_t == 10*CD - 1) begin
      if (sz > 0) pop = 1'b1;
      else        m_in_frame = 1'b0;
    end else begin
      m_t++;
    end
    if (pop) begin
      m_byte     = m_q.pop_front();
      m_in_frame = 1'b1;
      m_t        = 0;
    end
    if (v && sz >= DEP)  m_ovf = 1'b1;
    else if (clr)        m_ovf = 1'b0;
    if (v && sz < DEP)   m_q.push_back(d);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".tx"},       32'(tx),       32'(m_tx));
    chk({tag, ".busy"},     32'(busy),     32'(m_active || (m_q.size() > 0)));
    chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".level"},    32'(level),    32'(m_q.size()));
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic clr, input string tag);
    uart_valid = v;
    uart_data  = d;
    ovf_clr    = clr;
    @(posedge clk);
    model_edge(v, d, clr);
    #1;
    if (int'(level) > peak) peak = int'(level);
    check_all(tag);
    uart_valid = 1'b0;
    ovf_clr    = 1'b0;
  endtask

  task automatic idle(input int n, input string tag);
    repeat (n) step(1'b0, 8'd0, 1'b0, tag);
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle(3, "idle");

    // Single byte 0xA5: tx falls two edges after the push, busy ends after 40
    step(1'b1, 8'hA5, 1'b0, "a5_push");
    step(1'b0, 8'd0, 1'b0, "a5_n1");
    chk("a5_tx_n1", 32'(tx), 32'd1);
    step(1'b0, 8'd0, 1'b0, "a5_n2");
    chk("a5_tx_fall_n2", 32'(tx), 32'd0);
    idle(39, "a5_frame");
    chk("a5_busy_n41", 32'(busy), 32'd1);
    step(1'b0, 8'd0, 1'b0, "a5_n42");
    chk("a5_busy_end", 32'(busy), 32'd0);
    idle(5, "a5_tail");

    // Back-to-back 0x00 / 0xFF: busy high 2 latency + 80 frame cycles
    cnt = 0;
    step(1'b1, 8'h00, 1'b0, "b2b_0");
    if (busy) cnt++;
    step(1'b1, 8'hFF, 1'b0, "b2b_1");
    if (busy) cnt++;
    for (int i = 0; i < 90; i++) begin
      step(1'b0, 8'd0, 1'b0, "b2b_run");
      if (busy) cnt++;
    end
    chk("b2b_busy_cycles", 32'(cnt), 32'd82);

    // Overflow: 18 consecutive bytes, byte 17 dropped
    peak = 0;
    for (int i = 0; i < 18; i++) step(1'b1, 8'(i), 1'b0, "ovf_fill");
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_peak", 32'(peak), 32'd16);
    idle(17*10*CD + 5, "ovf_drain");
    chk("ovf_drained", 32'(level), 32'd0);

    // Clear, then clear coincident with a drop
    step(1'b0, 8'd0, 1'b1, "clr");
    chk("clr_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 18; i++) step(1'b1, 8'(8'h40 + i), (i == 17), "clr_drop");
    chk("clr_drop_ovf", 32'(overflow), 32'd1);
    idle(17*10*CD + 5, "clr_drain");

    // Simultaneous push and pop while idle with one byte queued
    step(1'b1, 8'h3C, 1'b0, "pp_0");
    chk("pp_level_a", 32'(level), 32'd1);
    step(1'b1, 8'hC3, 1'b0, "pp_1");
    chk("pp_level_b", 32'(level), 32'd1);
    idle(2*10*CD + 5, "pp_drain");

    // Reset in the middle of a DATA bit with three bytes queued
    step(1'b1, 8'h96, 1'b0, "rst_q0");
    step(1'b1, 8'h11, 1'b0, "rst_q1");
    step(1'b1, 8'h22, 1'b0, "rst_q2");
    step(1'b1, 8'h33, 1'b0, "rst_q3");
    chk("rst_queued", 32'(level), 32'd3);
    idle(3*CD, "rst_pre");
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst_async");
    repeat (2) begin
      @(posedge clk);
      #1;
      check_all("rst_held");
    end
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 8'd0, 1'b0, "rst_after");
      if (!tx) cnt++;
    end
    chk("rst_no_residual", 32'(cnt), 32'd0);

    // Randomized traffic: sparse, then dense with random clears
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 39) == 0), 8'($urandom), ($urandom_range(0, 19) == 0), "rand_lo");
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 9) < 3), 8'($urandom), ($urandom_range(0, 19) == 0), "rand_hi");
    idle(17*10*CD + 20, "rand_drain");
    chk("rand_idle_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
